// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the multi-pattern serial sequence detector.
package seqdet_pkg;

  localparam int unsigned DefSeqW   = 8;
  localparam int unsigned DefNumPat = 4;

  // Per-pattern match counters stick here instead of wrapping.
  localparam logic [15:0] CntMax = 16'hFFFF;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seqdet_cmp.sv
// One pattern slot: programmable pattern/mask/enable, masked compare and registered match.
// SEQDET_MATCH_CNT_EN adds a saturating per-pattern match counter.
module seqdet_cmp
  import seqdet_pkg::*;
#(
  parameter int unsigned SEQ_W = DefSeqW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_i,
  input  logic             full_i,
  input  logic [SEQ_W-1:0] hist_i,
  input  logic             wr_i,
  input  logic [SEQ_W-1:0] pat_i,
  input  logic [SEQ_W-1:0] mask_i,
  input  logic             en_i,
  output logic             hit_o,
  output logic             match_o
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [15:0]      cnt_o
`endif
);

  logic [SEQ_W-1:0] pat_q, mask_q;
  logic             en_q, match_q;

  // Compared against the registers as they stood before this edge's write.
  assign hit_o   = sample_i && en_q && full_i && (((hist_i ^ pat_q) & mask_q) == '0);
  assign match_o = match_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pat_q   <= '0;
      mask_q  <= '0;
      en_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit_o;
      if (wr_i) begin
        pat_q  <= pat_i;
        mask_q <= mask_i;
        en_q   <= en_i;
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (wr_i) begin
      cnt_q <= '0;
    end else if (hit_o && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/seqdet_multi.sv
// Serial multi-pattern detector: shared history and fill counter feeding NUM_PAT compare slots.
// Optional SEQDET_MATCH_CNT_EN exposes per-pattern saturating match counters.
module seqdet_multi
  import seqdet_pkg::*;
#(
  parameter int unsigned SEQ_W   = DefSeqW,
  parameter int unsigned NUM_PAT = DefNumPat,
  parameter int unsigned SEL_W   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_bit,
  input  logic               in_valid,
  input  logic               ovl_en,
  input  logic               seq_wr,
  input  logic [SEL_W-1:0]   seq_sel,
  input  logic [SEQ_W-1:0]   seq_in,
  input  logic [SEQ_W-1:0]   mask_in,
  input  logic               pat_en_in,
  output logic [NUM_PAT-1:0] match,
  output logic               match_any
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [NUM_PAT*16-1:0] match_cnt
`endif
);

  localparam int unsigned     FillW    = clog2(SEQ_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(SEQ_W);

  logic [SEQ_W-1:0]   hist_q, hist_d, hist_next;
  logic [FillW-1:0]   fill_q, fill_d, fill_next;
  logic               full_next;
  logic [NUM_PAT-1:0] hit;

  always_comb begin
    hist_next = {hist_q[SEQ_W-2:0], in_bit};
    fill_next = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
    full_next = (fill_next == FillFull);
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (in_valid) begin
      hist_d = hist_next;
      // Non-overlapping mode: any hit forces every pattern to wait for SEQ_W fresh bits.
      fill_d = (!ovl_en && (|hit)) ? '0 : fill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  for (genvar p = 0; p < NUM_PAT; p++) begin : g_pat
    logic wr;
    // Out-of-range selects match no slot, so the write is dropped.
    assign wr = seq_wr && (seq_sel == SEL_W'(p));

    seqdet_cmp #(
      .SEQ_W(SEQ_W)
    ) u_cmp (
      .clk_i   (clk),
      .rst_ni  (reset),
      .sample_i(in_valid),
      .full_i  (full_next),
      .hist_i  (hist_next),
      .wr_i    (wr),
      .pat_i   (seq_in),
      .mask_i  (mask_in),
      .en_i    (pat_en_in),
      .hit_o   (hit[p]),
      .match_o (match[p])
`ifdef SEQDET_MATCH_CNT_EN
      ,
      .cnt_o   (match_cnt[p*16 +: 16])
`endif
    );
  end

  assign match_any = |match;

endmodule

// File: tb/tb_seqdet_multi.sv
// Directed plus randomized bench for seqdet_multi against a queue-based reference model.
// Covers match counters too when SEQDET_MATCH_CNT_EN is defined.
module tb_seqdet_multi;

  localparam int SEQ_W   = 8;
  localparam int NUM_PAT = 4;
  localparam int SEL_W   = 2;

  logic               clk;
  logic               reset;
  logic               in_bit;
  logic               in_valid;
  logic               ovl_en;
  logic               seq_wr;
  logic [SEL_W-1:0]   seq_sel;
  logic [SEQ_W-1:0]   seq_in;
  logic [SEQ_W-1:0]   mask_in;
  logic               pat_en_in;
  logic [NUM_PAT-1:0] match;
  logic               match_any;
`ifdef SEQDET_MATCH_CNT_EN
  logic [NUM_PAT*16-1:0] match_cnt;
`endif

  seqdet_multi #(
    .SEQ_W  (SEQ_W),
    .NUM_PAT(NUM_PAT),
    .SEL_W  (SEL_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .ovl_en   (ovl_en),
    .seq_wr   (seq_wr),
    .seq_sel  (seq_sel),
    .seq_in   (seq_in),
    .mask_in  (mask_in),
    .pat_en_in(pat_en_in),
    .match    (match),
    .match_any(match_any)
`ifdef SEQDET_MATCH_CNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: the valid bits seen since the last restart, oldest first.
  bit               q[$];
  logic [SEQ_W-1:0] m_pat[NUM_PAT];
  logic [SEQ_W-1:0] m_mask[NUM_PAT];
  bit               m_en[NUM_PAT];
  int               m_cnt[NUM_PAT];
  logic [NUM_PAT-1:0] exp_match;

  function automatic bit pat_ok(input int p);
    for (int k = 0; k < SEQ_W; k++) begin
      if (m_mask[p][SEQ_W-1-k] && (q[k] != m_pat[p][SEQ_W-1-k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit r, input bit v, input bit b, input bit o, input bit w,
                      input logic [SEL_W-1:0] s, input logic [SEQ_W-1:0] pt,
                      input logic [SEQ_W-1:0] mk, input bit e);
    @(negedge clk);
    reset = r; in_valid = v; in_bit = b; ovl_en = o;
    seq_wr = w; seq_sel = s; seq_in = pt; mask_in = mk; pat_en_in = e;

    exp_match = '0;
    if (!r) begin
      q.delete();
      for (int p = 0; p < NUM_PAT; p++) begin
        m_pat[p] = '0; m_mask[p] = '0; m_en[p] = 1'b0; m_cnt[p] = 0;
      end
    end else begin
      if (v) begin
        q.push_back(b);
        if (q.size() > SEQ_W) void'(q.pop_front());
        if (q.size() == SEQ_W) begin
          for (int p = 0; p < NUM_PAT; p++) exp_match[p] = m_en[p] && pat_ok(p);
        end
        if (!o && (exp_match != '0)) q.delete();
      end
      for (int p = 0; p < NUM_PAT; p++) begin
        if (w && (int'(s) == p)) begin
          m_pat[p] = pt; m_mask[p] = mk; m_en[p] = e; m_cnt[p] = 0;
        end else if (exp_match[p] && (m_cnt[p] < 65535)) begin
          m_cnt[p]++;
        end
      end
    end

    @(posedge clk);
    #1;
    vectors++;
    assert (match === exp_match) else begin
      miscompares++;
      $error("FAIL match: got %b want %b at %0t", match, exp_match, $time);
    end
    vectors++;
    assert (match_any === (|exp_match)) else begin
      miscompares++;
      $error("FAIL match_any: got %b want %b at %0t", match_any, |exp_match, $time);
    end
`ifdef SEQDET_MATCH_CNT_EN
    for (int p = 0; p < NUM_PAT; p++) begin
      vectors++;
      assert (match_cnt[p*16 +: 16] === 16'(m_cnt[p])) else begin
        miscompares++;
        $error("FAIL match_cnt[%0d]: got %0d want %0d at %0t", p, match_cnt[p*16 +: 16],
               m_cnt[p], $time);
      end
    end
`endif
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input bit o);
    for (int i = n - 1; i >= 0; i--) step(1, 1, bits[i], o, 0, '0, '0, '0, 0);
  endtask

  task automatic prog(input logic [SEL_W-1:0] s, input logic [SEQ_W-1:0] pt,
                      input logic [SEQ_W-1:0] mk, input bit e);
    step(1, 0, 0, 1, 1, s, pt, mk, e);
  endtask

  task automatic do_reset();
    step(0, 1, 1, 1, 1, '0, 8'hFF, 8'hFF, 1);
  endtask

  initial begin
    bit ovl;
    vectors = 0; miscompares = 0;
    reset = 1; in_bit = 0; in_valid = 0; ovl_en = 1; seq_wr = 0;
    seq_sel = '0; seq_in = '0; mask_in = '0; pat_en_in = 0;

    do_reset();
    do_reset();

    // Basic exact-match pattern
    prog(0, 8'b01001101, 8'hFF, 1);
    feed(32'b01001101, 8, 1);
    step(1, 0, 0, 1, 0, '0, '0, '0, 0);

    // Overlapping vs non-overlapping
    do_reset();
    prog(1, 8'b10101010, 8'hFF, 1);
    feed(32'b1010101010, 10, 1);
    do_reset();
    prog(1, 8'b10101010, 8'hFF, 1);
    feed(32'b1010101010, 10, 0);

    // Don't-care nibble
    prog(2, 8'b1010_0000, 8'hF0, 1);
    feed(32'b1010_0110, 8, 0);
    feed(32'b1010_1111, 8, 0);
    feed(32'b1110_0000, 8, 0);

    // Reset mid-sequence clears history and enables
    do_reset();
    prog(0, 8'b01001101, 8'hFF, 1);
    feed(32'b01001, 5, 1);
    do_reset();
    feed(32'b101, 3, 1);
    feed(32'b01001101, 8, 1);
    prog(0, 8'b01001101, 8'hFF, 1);
    feed(32'b101, 3, 1);
    feed(32'b01001101, 8, 1);

    // Invalid cycles with garbage, then rewrite on the completing edge
    do_reset();
    prog(0, 8'b01001101, 8'hFF, 1);
    feed(32'b0100, 4, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 1'($urandom), 1, 0, '0, '0, '0, 0);
    feed(32'b110, 3, 1);
    step(1, 1, 1, 1, 1, 2'd0, 8'hFF, 8'hFF, 1);
    feed(32'hFF, 8, 1);

    // All-zero mask matches every sample once full
    prog(3, 8'h00, 8'h00, 1);
    feed(32'b101, 3, 1);

`ifdef SEQDET_MATCH_CNT_EN
    do_reset();
    prog(0, 8'h00, 8'h00, 1);
    feed(32'h3FF, 10, 1);
    for (int i = 0; i < 70000; i++) step(1, 1, 1'($urandom), 1, 0, '0, '0, '0, 0);
`endif

    // Randomized traffic with sparse masks so hits are frequent
    do_reset();
    ovl = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) ovl = 1'($urandom);
      if ($urandom_range(19) == 0)
        step(($urandom_range(199) != 0), ($urandom_range(3) != 0), 1'($urandom), ovl, 1,
             2'($urandom), 8'($urandom), 8'($urandom & $urandom & $urandom),
             ($urandom_range(3) != 0));
      else
        step(($urandom_range(199) != 0), ($urandom_range(3) != 0), 1'($urandom), ovl, 0,
             2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
